// File: rtl/sm3_compress_multi.sv
// sm3_compress_multi: SM3 compression engine, RPC rounds per clock, chains IV across the blocks of a message
// Ports: clk/rst (async, active high); in_valid/in_ready/in_data/in_first/in_last block input handshake;
//        out_valid/out_ready/hash_out digest output handshake; busy high while rounds or feed-forward run.
module sm3_compress_multi #(
  parameter int RPC = 1,
  parameter logic [255:0] IV = 256'h7380166f4914b2b9172442d7da8a0600a96f30bc163138aae38dee4db0fb0e4e
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [511:0] in_data,
  input  logic         in_first,
  input  logic         in_last,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [255:0] hash_out,
  output logic         busy
);
  if (!(RPC == 1 || RPC == 2 || RPC == 4 || RPC == 8)) begin : g_bad_rpc
    $error("RPC must be 1, 2, 4 or 8");
  end
  typedef enum logic [1:0] {IDLE, ROUND, FEED, HOLD} state_t;
  state_t state_q, state_d;
  logic [5:0] j_q, j_d;
  logic [511:0] w_q, w_d, w_nxt;
  logic [255:0] s_q, s_d, s_nxt, v_q, v_d, hash_q, hash_d;
  logic last_q, last_d, in_ready_q, in_ready_d, hs;
  function automatic logic [31:0] rotl(input logic [31:0] x, input logic [4:0] n);
    logic [63:0] t;
    t = {x, x} << n;
    return t[63:32];
  endfunction
  function automatic logic [31:0] p0(input logic [31:0] x);
    return x ^ rotl(x, 5'd9) ^ rotl(x, 5'd17);
  endfunction
  function automatic logic [31:0] p1(input logic [31:0] x);
    return x ^ rotl(x, 5'd15) ^ rotl(x, 5'd23);
  endfunction
  function automatic logic [255:0] sm3_round(input logic [255:0] s, input logic [5:0] j,
                                             input logic [31:0] w, input logic [31:0] wp);
    logic [31:0] a, b, c, d, e, f, g, h, t, ss1, ss2, tt1, tt2;
    {a, b, c, d, e, f, g, h} = s;
    t   = rotl(j < 6'd16 ? 32'h79cc4519 : 32'h7a879d8a, j[4:0]);
    ss1 = rotl(rotl(a, 5'd12) + e + t, 5'd7);
    ss2 = ss1 ^ rotl(a, 5'd12);
    tt1 = (j < 6'd16 ? a ^ b ^ c : (a & b) | (a & c) | (b & c)) + d + ss2 + wp;
    tt2 = (j < 6'd16 ? e ^ f ^ g : (e & f) | (~e & g)) + h + ss1 + w;
    return {tt1, a, rotl(b, 5'd9), c, p0(tt2), e, rotl(f, 5'd19), g};
  endfunction
  assign hs = in_valid & in_ready_q;
  // ext[0..15] is the current window W[j..j+15]; ext[16..] are the words the window shifts in this cycle
  always_comb begin
    logic [31:0] ext [0:15+RPC];
    logic [255:0] s [0:RPC];
    for (int i = 0; i < 16; i++) ext[i] = w_q[511-32*i -: 32];
    for (int n = 16; n < 16 + RPC; n++)
      ext[n] = p1(ext[n-16] ^ ext[n-9] ^ rotl(ext[n-3], 5'd15)) ^ rotl(ext[n-13], 5'd7) ^ ext[n-6];
    s[0] = s_q;
    for (int k = 0; k < RPC; k++) s[k+1] = sm3_round(s[k], j_q + 6'(k), ext[k], ext[k] ^ ext[k+4]);
    s_nxt = s[RPC];
    w_nxt = '0;
    for (int i = 0; i < 16; i++) w_nxt[511-32*i -: 32] = ext[i+RPC];
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  state_d = hs ? ROUND : IDLE;
      ROUND: state_d = (7'(j_q) + 7'(RPC) == 7'd64) ? FEED : ROUND;
      FEED:  state_d = last_q ? HOLD : IDLE;
      HOLD:  state_d = out_ready ? IDLE : HOLD;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    j_d        = state_q == ROUND ? j_q + 6'(RPC) : 6'd0;
    w_d        = hs ? in_data : state_q == ROUND ? w_nxt : w_q;
    s_d        = hs ? (in_first ? IV : v_q) : state_q == ROUND ? s_nxt : s_q;
    v_d        = hs ? (in_first ? IV : v_q) : state_q == FEED ? s_q ^ v_q : v_q;
    last_d     = hs ? in_last : last_q;
    hash_d     = (state_q == FEED && last_q) ? s_q ^ v_q : hash_q;
    in_ready_d = state_d == IDLE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      j_q        <= '0;
      w_q        <= '0;
      s_q        <= '0;
      v_q        <= IV;
      last_q     <= 1'b0;
      hash_q     <= '0;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      j_q        <= j_d;
      w_q        <= w_d;
      s_q        <= s_d;
      v_q        <= v_d;
      last_q     <= last_d;
      hash_q     <= hash_d;
      in_ready_q <= in_ready_d;
    end
  end
  always_comb begin
    in_ready  = in_ready_q;
    out_valid = state_q == HOLD;
    busy      = state_q == ROUND || state_q == FEED;
    hash_out  = hash_q;
  end
endmodule

// File: tb/tb_sm3_compress_multi.sv
// tb_sm3_compress_multi: directed-vector bench for sm3_compress_multi at RPC 1, 4 and 8
module tb_sm3_compress_multi;
  localparam logic [255:0] ABC_H  = 256'h66c7f0f462eeedd9d1f2d46bdc10e4e24167c4875cf2f7a2297da02b8f4ba8e0;
  localparam logic [255:0] ABCD_H = 256'hdebe9ff92275b8a138604889c18e5a4d6fdb70e5387e5765293dcba39c0c5732;
  localparam logic [511:0] ABC_B   = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] ABCD_B1 = {16{32'h61626364}};
  localparam logic [511:0] ABCD_B2 = {32'h80000000, 448'h0, 32'h00000200};
  logic clk = 1'b0, rst = 1'b1;
  logic [2:0] in_valid = '0, out_ready = '0;
  logic [511:0] in_data = '0;
  logic in_first = 1'b0, in_last = 1'b0;
  wire [2:0] in_ready, out_valid, busy;
  wire [255:0] hash [0:2];
  int tests = 0, fails = 0, lat, bsy;
  logic [255:0] held;
  always #5 clk = ~clk;
  sm3_compress_multi #(.RPC(1)) u1 (.clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_data(in_data), .in_first(in_first), .in_last(in_last), .out_valid(out_valid[0]),
    .out_ready(out_ready[0]), .hash_out(hash[0]), .busy(busy[0]));
  sm3_compress_multi #(.RPC(4)) u4 (.clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_data(in_data), .in_first(in_first), .in_last(in_last), .out_valid(out_valid[1]),
    .out_ready(out_ready[1]), .hash_out(hash[1]), .busy(busy[1]));
  sm3_compress_multi #(.RPC(8)) u8 (.clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .in_data(in_data), .in_first(in_first), .in_last(in_last), .out_valid(out_valid[2]),
    .out_ready(out_ready[2]), .hash_out(hash[2]), .busy(busy[2]));
  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic send(input int i, input logic [511:0] d, input logic f, input logic l);
    int n = 0;
    @(negedge clk);
    in_data = d;
    in_first = f;
    in_last = l;
    in_valid[i] = 1'b1;
    while (!in_ready[i] && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("in_ready_wait", in_ready[i], 1);
    @(posedge clk);
    #1 in_valid[i] = 1'b0;
  endtask
  task automatic wait_done(input int i, output int l, output int b);
    bit done = 0;
    l = 1;
    b = 0;
    while (!done) begin
      @(negedge clk);
      if (busy[i]) b++;
      if (out_valid[i] || in_ready[i] || l >= 300) done = 1;
      else begin
        @(posedge clk);
        l++;
      end
    end
    check("done_in_time", l < 300, 1);
  endtask
  task automatic drain(input int i);
    @(negedge clk);
    out_ready[i] = 1'b1;
    @(posedge clk);
    #1 out_ready[i] = 1'b0;
  endtask
  initial begin
    #12;
    check("rst_in_ready", in_ready, 3'b000);
    check("rst_out_valid", out_valid, 3'b000);
    check("rst_busy", busy, 3'b000);
    check("rst_hash", hash[0], 0);
    @(negedge clk) rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", in_ready, 3'b111);
    send(0, ABC_B, 1, 1);
    wait_done(0, lat, bsy);
    check("abc_r1_latency", lat, 66);
    check("abc_r1_busy", bsy, 65);
    check("abc_r1_valid", out_valid[0], 1);
    check("abc_r1_hash", hash[0], ABC_H);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      check("hold_valid", out_valid[0], 1);
      check("hold_hash", hash[0], ABC_H);
      check("hold_in_ready", in_ready[0], 0);
    end
    @(negedge clk);
    out_ready[0] = 1'b1;
    #1 check("ready_not_same_cycle", in_ready[0], 0);
    @(posedge clk);
    #1 out_ready[0] = 1'b0;
    @(negedge clk);
    check("ready_after_take", in_ready[0], 1);
    check("valid_after_take", out_valid[0], 0);
    check("hash_kept", hash[0], ABC_H);
    send(1, ABC_B, 1, 1);
    wait_done(1, lat, bsy);
    check("abc_r4_latency", lat, 18);
    check("abc_r4_busy", bsy, 17);
    check("abc_r4_hash", hash[1], ABC_H);
    drain(1);
    send(2, ABC_B, 1, 1);
    wait_done(2, lat, bsy);
    check("abc_r8_latency", lat, 10);
    check("abc_r8_busy", bsy, 9);
    check("abc_r8_hash", hash[2], ABC_H);
    drain(2);
    send(0, ABCD_B1, 1, 0);
    wait_done(0, lat, bsy);
    check("abcd_b1_no_valid", out_valid[0], 0);
    check("abcd_b1_back_idle", lat, 66);
    check("abcd_b1_hash_kept", hash[0], ABC_H);
    send(0, ABCD_B2, 0, 1);
    wait_done(0, lat, bsy);
    check("abcd_hash", hash[0], ABCD_H);
    drain(0);
    send(0, ABCD_B1, 1, 0);
    wait_done(0, lat, bsy);
    check("abandon_no_valid", out_valid[0], 0);
    send(0, ABC_B, 1, 1);
    wait_done(0, lat, bsy);
    check("restart_hash", hash[0], ABC_H);
    drain(0);
    send(0, ABC_B, 1, 1);
    repeat (30) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_in_ready", in_ready[0], 0);
    check("midrst_out_valid", out_valid[0], 0);
    check("midrst_busy", busy[0], 0);
    check("midrst_hash", hash[0], 0);
    @(negedge clk) rst = 1'b0;
    send(0, ABC_B, 1, 1);
    wait_done(0, lat, bsy);
    check("after_rst_latency", lat, 66);
    check("after_rst_hash", hash[0], ABC_H);
    drain(0);
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    send(0, ABC_B, 0, 1);
    wait_done(0, lat, bsy);
    check("nonfirst_after_rst_hash", hash[0], ABC_H);
    drain(0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
